instr_fetch_sequencer: RTL and testbench

Controller that drives the instruction transmitter's `syn`/`ack`/`last` interface and delivers one complete program of `DEPTH` instructions downstream over a valid/ready handshake. It issues one `syn` request per instruction, limited by credit so a small internal FIFO can never overflow. It checks that the transmitter's `last` flag lines up with the expected program length, and reports done and error status. It sits between the instruction transmitter and the core's fetch/decode stage.

---
 rtl/instr_fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Fetches one program of DEPTH instructions from the transmitter under credit
// control, buffers them in a skid FIFO and streams them out over valid/ready.
module instr_fetch_sequencer #(
  parameter int IWIDTH     = 32,
  parameter int DEPTH      = 36,
  parameter int FIFO_DEPTH = 4,
  parameter int CWIDTH     = $clog2(DEPTH + 1)
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              f_i_start,
  output logic              f_o_syn,
  input  logic [IWIDTH-1:0] f_i_instr,
  input  logic              f_i_ack,
  input  logic              f_i_last,
  output logic [IWIDTH-1:0] f_o_instr,
  output logic              f_o_valid,
  input  logic              f_i_ready,
  output logic              f_o_busy,
  output logic              f_o_done,
  output logic              f_o_err,
  output logic [CWIDTH-1:0] f_o_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;

  localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);
  localparam logic [CWIDTH-1:0] LAST_C  = CWIDTH'(DEPTH - 1);
  localparam logic [OW-1:0]     FD_CNT  = OW'(FIFO_DEPTH);
  localparam logic [OW:0]       FD_SUM  = (OW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CWIDTH-1:0] issued;
  logic [CWIDTH-1:0] acked;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     fifo_count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [IWIDTH-1:0] mem [FIFO_DEPTH];

  logic [OW:0] credit_used;
  logic        start_ok;
  logic        ack_ok;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        last_exp;
  logic        err_set;

  // One extra bit so the credit sum can never wrap before the compare.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

  assign f_o_valid = (fifo_count != '0);
  assign fifo_full = (fifo_count == FD_CNT);
  assign pop       = f_o_valid && f_i_ready;
  assign ack_ok    = f_i_ack && (outstanding != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = ack_ok && (!fifo_full || pop);
  assign last_exp  = (acked == LAST_C);
  assign start_ok  = (state == S_IDLE) && f_i_start;

  assign err_set = (f_i_ack && (outstanding == '0))
                || (ack_ok && fifo_full && !pop)
                || (ack_ok && (f_i_last != last_exp));

  assign f_o_instr = f_o_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    f_o_syn   = 1'b0;
    f_o_busy  = 1'b0;
    f_o_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (f_i_start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        f_o_busy = 1'b1;
        f_o_syn  = (issued < DEPTH_C) && (credit_used < FD_SUM);
        if (issued == DEPTH_C) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        f_o_busy = 1'b1;
        if (!f_o_valid && (outstanding == '0)) state_nxt = S_DONE;
      end
      S_DONE: begin
        f_o_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      issued      <= '0;
      acked       <= '0;
      outstanding <= '0;
      f_o_count   <= '0;
      f_o_err     <= 1'b0;
    end else if (start_ok) begin
      issued      <= '0;
      acked       <= '0;
      outstanding <= '0;
      f_o_count   <= '0;
      f_o_err     <= 1'b0;
    end else begin
      if (f_o_syn) issued <= issued + 1'b1;
      if (ack_ok)  acked  <= acked + 1'b1;
      if (f_o_syn && !ack_ok) begin
        outstanding <= outstanding + 1'b1;
      end else if (!f_o_syn && ack_ok) begin
        outstanding <= outstanding - 1'b1;
      end
      if (pop && (f_o_count != DEPTH_C)) f_o_count <= f_o_count + 1'b1;
      if (err_set) f_o_err <= 1'b1;
    end
  end

  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the head output is
  // gated by valid, so stale entries are never visible.
  always_ff @(posedge f_clk) begin
    if (push) mem[wr_ptr] <= f_i_instr;
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer with a behavioural transmitter
// that answers each syn with an ack one cycle later.
module tb_instr_fetch_sequencer;

  localparam int IWIDTH     = 32;
  localparam int DEPTH      = 36;
  localparam int FIFO_DEPTH = 4;
  localparam int CWIDTH     = $clog2(DEPTH + 1);

  logic              f_clk = 1'b0;
  logic              f_rst;
  logic              f_i_start;
  logic              f_o_syn;
  logic [IWIDTH-1:0] f_i_instr;
  logic              f_i_ack;
  logic              f_i_last;
  logic [IWIDTH-1:0] f_o_instr;
  logic              f_o_valid;
  logic              f_i_ready;
  logic              f_o_busy;
  logic              f_o_done;
  logic              f_o_err;
  logic [CWIDTH-1:0] f_o_count;

  instr_fetch_sequencer #(
    .IWIDTH    (IWIDTH),
    .DEPTH     (DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CWIDTH    (CWIDTH)
  ) dut (
    .f_clk    (f_clk),
    .f_rst    (f_rst),
    .f_i_start(f_i_start),
    .f_o_syn  (f_o_syn),
    .f_i_instr(f_i_instr),
    .f_i_ack  (f_i_ack),
    .f_i_last (f_i_last),
    .f_o_instr(f_o_instr),
    .f_o_valid(f_o_valid),
    .f_i_ready(f_i_ready),
    .f_o_busy (f_o_busy),
    .f_o_done (f_o_done),
    .f_o_err  (f_o_err),
    .f_o_count(f_o_count)
  );

  always #5 f_clk = ~f_clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: program memory holds 0..DEPTH-1, last on the final word.
  logic [IWIDTH-1:0] tx_mem [DEPTH];
  int                tx_addr;
  logic              tx_ack;
  logic              tx_last;
  logic [IWIDTH-1:0] tx_instr;
  logic              spur_ack;
  int                inject_last_addr;

  initial for (int i = 0; i < DEPTH; i++) tx_mem[i] = IWIDTH'(i);

  always @(posedge f_clk) begin
    if (f_rst) begin
      tx_addr  <= 0;
      tx_ack   <= 1'b0;
      tx_last  <= 1'b0;
      tx_instr <= '0;
    end else begin
      tx_ack  <= f_o_syn;
      tx_last <= 1'b0;
      if (f_o_syn) begin
        tx_instr <= tx_mem[tx_addr];
        tx_last  <= (tx_addr == DEPTH - 1) || (tx_addr == inject_last_addr);
        tx_addr  <= (tx_addr == DEPTH - 1) ? 0 : tx_addr + 1;
      end
    end
  end

  assign f_i_ack   = tx_ack | spur_ack;
  assign f_i_instr = tx_instr;
  assign f_i_last  = tx_last;

  // Scoreboard and observation counters, all sampled on the falling edge.
  logic [IWIDTH-1:0] exp_q [$];
  int cyc = 0;
  int syn_cnt, pops, done_cnt, max_credit;
  int start_idx, first_syn, first_valid, done_idx;

  always @(negedge f_clk) begin
    if (!f_rst) begin
      if ((syn_cnt - pops) > max_credit) max_credit = syn_cnt - pops;
      if (f_i_start && !f_o_busy && !f_o_done) begin
        start_idx   = cyc;
        first_syn   = -1;
        first_valid = -1;
      end
      if (f_o_syn) begin
        syn_cnt++;
        if (first_syn < 0) first_syn = cyc;
      end
      if (f_o_valid && first_valid < 0) first_valid = cyc;
      if (f_o_valid && f_i_ready) begin
        pops++;
        if (exp_q.size() == 0) check("pop_unexpected", f_o_instr, -1);
        else check("pop_data", f_o_instr, exp_q.pop_front());
      end
      if (f_o_done) begin
        done_cnt++;
        done_idx = cyc;
        check("done_after_last_pop", pops, DEPTH);
      end
    end
    cyc++;
  end

  int ready_mode;  // 0: ready high, 1: random, 2: ready low

  task automatic step();
    @(posedge f_clk);
    #1;
    case (ready_mode)
      0:       f_i_ready = 1'b1;
      1:       f_i_ready = 1'($urandom_range(0, 1));
      default: f_i_ready = 1'b0;
    endcase
  endtask

  task automatic apply_reset();
    f_rst = 1'b1;
    exp_q.delete();
    step();
    @(negedge f_clk);
    check("rst_syn",   f_o_syn,   0);
    check("rst_valid", f_o_valid, 0);
    check("rst_busy",  f_o_busy,  0);
    check("rst_done",  f_o_done,  0);
    check("rst_err",   f_o_err,   0);
    check("rst_instr", f_o_instr, 0);
    check("rst_count", f_o_count, 0);
    f_rst = 1'b0;
    step();
  endtask

  task automatic start_run();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(tx_mem[i]);
    syn_cnt = 0; pops = 0; done_cnt = 0; max_credit = 0;
    f_i_start = 1'b1;
    step();
    f_i_start = 1'b0;
  endtask

  task automatic pulse_start();
    f_i_start = 1'b1;
    step();
    f_i_start = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pops < n && k < budget) begin step(); k++; end
    if (pops < n) check("pops_timeout", pops, n);
  endtask

  task automatic wait_syns(input int n, input int budget);
    int k = 0;
    while (syn_cnt < n && k < budget) begin step(); k++; end
    if (syn_cnt < n) check("syn_timeout", syn_cnt, n);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin step(); k++; end
    if (done_cnt == 0) check("done_timeout", 0, 1);
  endtask

  task automatic end_checks(input logic exp_err);
    repeat (3) step();
    check("done_pulses", done_cnt, 1);
    check("out_count",   f_o_count, DEPTH);
    check("syn_cycles",  syn_cnt, DEPTH);
    check("queue_left",  exp_q.size(), 0);
    check("err_final",   f_o_err, exp_err);
    check("credit_ok",   (max_credit <= FIFO_DEPTH), 1);
  endtask

  initial begin
    f_rst = 1'b1; f_i_start = 1'b0; f_i_ready = 1'b0; spur_ack = 1'b0;
    inject_last_addr = -1; ready_mode = 0;
    syn_cnt = 0; pops = 0; done_cnt = 0; max_credit = 0;
    start_idx = 0; first_syn = -1; first_valid = -1; done_idx = 0;
    apply_reset();

    // Spurious ack while idle: sticky error, nothing enters the FIFO.
    spur_ack = 1'b1;
    step();
    spur_ack = 1'b0;
    check("spur_err",   f_o_err,   1);
    check("spur_valid", f_o_valid, 0);
    repeat (3) step();
    check("spur_err_sticky", f_o_err,   1);
    check("spur_empty",      f_o_valid, 0);

    // Full run with ready held high; start also clears the earlier error.
    ready_mode = 0;
    start_run();
    check("start_clears_err", f_o_err, 0);
    wait_done(400);
    check("lat_syn",   first_syn - start_idx,   1);
    check("lat_valid", first_valid - start_idx, 3);
    check("lat_done",  done_idx - start_idx,    DEPTH + 4);
    end_checks(1'b0);

    // Backpressure: ready low for 20 cycles, credit stops syn at FIFO_DEPTH.
    ready_mode = 2;
    start_run();
    repeat (19) step();
    check("bp_syn_cnt", syn_cnt,   FIFO_DEPTH);
    check("bp_syn_low", f_o_syn,   0);
    check("bp_valid",   f_o_valid, 1);
    check("bp_head",    f_o_instr, 0);
    check("bp_no_pops", pops,      0);
    ready_mode = 0;
    wait_done(400);
    end_checks(1'b0);

    // Start pulses mid-FETCH and during DRAIN are ignored.
    ready_mode = 0;
    start_run();
    wait_syns(10, 200);
    check("busy_fetch", f_o_busy, 1);
    pulse_start();
    wait_syns(DEPTH, 400);
    ready_mode = 2;
    repeat (4) step();
    check("busy_drain", f_o_busy, 1);
    pulse_start();
    ready_mode = 0;
    wait_done(400);
    end_checks(1'b0);

    // Wrong last flag on the 20th ack: error set, data still delivered.
    inject_last_addr = 19;
    start_run();
    wait_pops(10, 200);
    check("err_before_inject", f_o_err, 0);
    wait_pops(25, 200);
    check("err_after_inject", f_o_err, 1);
    wait_done(400);
    end_checks(1'b1);
    inject_last_addr = -1;

    // Reset after 10 pops, then a fresh run refetches from instruction 0.
    start_run();
    wait_pops(10, 200);
    apply_reset();
    start_run();
    wait_done(400);
    end_checks(1'b0);

    // Random ready, 200 programs.
    ready_mode = 1;
    for (int r = 0; r < 200; r++) begin
      start_run();
      wait_done(2000);
      end_checks(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
